// File: rtl/dmi_arb_pkg.sv
// Shared types for the two-requester DMI arbiter.
// State encoding, DMI op/response codes and the request header.
package dmi_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RETURN
  } arb_state_e;

  typedef enum logic [1:0] {
    OP_NOP   = 2'd0,
    OP_READ  = 2'd1,
    OP_WRITE = 2'd2
  } dmi_op_e;

  localparam logic [1:0] RESP_OK   = 2'd0;
  localparam logic [1:0] RESP_FAIL = 2'd2;
  localparam logic [1:0] RESP_BUSY = 2'd3;

  // Width-independent part of a captured request
  typedef struct packed {
    logic       owner;
    logic [1:0] op;
  } arb_req_t;

endpackage

// File: rtl/dmi_rr_pick2.sv
// Two-way round-robin pick: lone requester wins,
// a tie goes to the requester named by ptr (0=a, 1=b).
module dmi_rr_pick2
  import dmi_arb_pkg::*;
(
  input  logic valid_a,
  input  logic valid_b,
  input  logic ptr,
  output logic grant,
  output logic any
);

  assign any   = valid_a | valid_b;
  assign grant = (valid_a & valid_b) ? ptr : valid_b;

endmodule

// File: rtl/dmi_arbiter.sv
// Arbitrates two DMI masters onto one debug module, one transaction
// in flight. Optional response timeout: define DMI_ARB_TIMEOUT_EN.
module dmi_arbiter
  import dmi_arb_pkg::*;
#(
  parameter int ADDR_W         = 5,
  parameter int DATA_W         = 34,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_req_valid,
  output logic              a_req_ready,
  input  logic [ADDR_W-1:0] a_req_addr,
  input  logic [1:0]        a_req_op,
  input  logic [DATA_W-1:0] a_req_data,
  output logic              a_resp_valid,
  input  logic              a_resp_ready,
  output logic [1:0]        a_resp_resp,
  output logic [DATA_W-1:0] a_resp_data,
  input  logic              b_req_valid,
  output logic              b_req_ready,
  input  logic [ADDR_W-1:0] b_req_addr,
  input  logic [1:0]        b_req_op,
  input  logic [DATA_W-1:0] b_req_data,
  output logic              b_resp_valid,
  input  logic              b_resp_ready,
  output logic [1:0]        b_resp_resp,
  output logic [DATA_W-1:0] b_resp_data,
  output logic              dmi_req_valid,
  input  logic              dmi_req_ready,
  output logic [ADDR_W-1:0] dmi_req_addr,
  output logic [1:0]        dmi_req_op,
  output logic [DATA_W-1:0] dmi_req_data,
  input  logic              dmi_resp_valid,
  output logic              dmi_resp_ready,
  input  logic [1:0]        dmi_resp_resp,
  input  logic [DATA_W-1:0] dmi_resp_data
);

  arb_state_e        state;
  arb_req_t          req_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [1:0]        resp_q;
  logic [DATA_W-1:0] rdata_q;
  logic              ptr;
  logic              grant;
  logic              any;
  logic              idle;
  logic              own_rdy;

  dmi_rr_pick2 u_pick (
    .valid_a (a_req_valid),
    .valid_b (b_req_valid),
    .ptr     (ptr),
    .grant   (grant),
    .any     (any)
  );

  assign idle    = (state == ST_IDLE);
  assign own_rdy = req_q.owner ? b_resp_ready : a_resp_ready;

  // Ready is only offered out of reset so nothing looks accepted
  assign a_req_ready = reset & idle & any & ~grant;
  assign b_req_ready = reset & idle & any & grant;

  assign dmi_req_valid = (state == ST_ISSUE);
  assign dmi_req_addr  = addr_q;
  assign dmi_req_op    = req_q.op;
  assign dmi_req_data  = data_q;

  assign a_resp_valid = (state == ST_RETURN) & ~req_q.owner;
  assign b_resp_valid = (state == ST_RETURN) & req_q.owner;
  assign a_resp_resp  = resp_q;
  assign b_resp_resp  = resp_q;
  assign a_resp_data  = rdata_q;
  assign b_resp_data  = rdata_q;

`ifdef DMI_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q;
  logic             drain_q;
  logic             timeout;

  assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // A late response from a timed-out access is swallowed here
  assign dmi_resp_ready = (state == ST_WAIT) | (idle & drain_q);
`else
  logic unused_timeout;

  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign dmi_resp_ready = (state == ST_WAIT);
`endif

  // Transaction FSM with captured request and response
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      ptr     <= 1'b0;
      req_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      resp_q  <= '0;
      rdata_q <= '0;
`ifdef DMI_ARB_TIMEOUT_EN
      cnt_q   <= '0;
      drain_q <= 1'b0;
`endif
    end else begin
      unique case (state)
        ST_IDLE: begin
`ifdef DMI_ARB_TIMEOUT_EN
          if (drain_q && dmi_resp_valid) drain_q <= 1'b0;
`endif
          if (any) begin
            req_q.owner <= grant;
            req_q.op    <= grant ? b_req_op : a_req_op;
            addr_q      <= grant ? b_req_addr : a_req_addr;
            data_q      <= grant ? b_req_data : a_req_data;
            state       <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (dmi_req_ready) begin
            state <= ST_WAIT;
`ifdef DMI_ARB_TIMEOUT_EN
            cnt_q <= '0;
`endif
          end
        end
        ST_WAIT: begin
`ifdef DMI_ARB_TIMEOUT_EN
          if (dmi_resp_valid && !drain_q) begin
            resp_q  <= dmi_resp_resp;
            rdata_q <= dmi_resp_data;
            state   <= ST_RETURN;
          end else if (timeout) begin
            resp_q  <= RESP_FAIL;
            rdata_q <= '0;
            drain_q <= 1'b1;
            state   <= ST_RETURN;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (dmi_resp_valid) drain_q <= 1'b0;
          end
`else
          if (dmi_resp_valid) begin
            resp_q  <= dmi_resp_resp;
            rdata_q <= dmi_resp_data;
            state   <= ST_RETURN;
          end
`endif
        end
        ST_RETURN: begin
          if (own_rdy) begin
            state <= ST_IDLE;
            ptr   <= ~req_q.owner;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmi_arbiter.sv
// Directed bench for dmi_arbiter: arbitration, stalls,
// response back-pressure and reset abandonment.
module tb_dmi_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        a_req_valid = 0, b_req_valid = 0;
  logic        a_req_ready, b_req_ready;
  logic [4:0]  a_req_addr = 0, b_req_addr = 0;
  logic [1:0]  a_req_op = 0, b_req_op = 0;
  logic [33:0] a_req_data = 0, b_req_data = 0;
  logic        a_resp_valid, b_resp_valid;
  logic        a_resp_ready = 1, b_resp_ready = 1;
  logic [1:0]  a_resp_resp, b_resp_resp;
  logic [33:0] a_resp_data, b_resp_data;
  logic        dmi_req_valid;
  logic        dmi_req_ready = 1;
  logic [4:0]  dmi_req_addr;
  logic [1:0]  dmi_req_op;
  logic [33:0] dmi_req_data;
  logic        dmi_resp_valid = 0;
  logic        dmi_resp_ready;
  logic [1:0]  dmi_resp_resp = 0;
  logic [33:0] dmi_resp_data = 0;

  int compared = 0;
  int mismatched = 0;
  int hs_cnt = 0;
  int b_rv_cnt = 0;

  dmi_arbiter #(
    .ADDR_W(5), .DATA_W(34), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .reset(reset),
    .a_req_valid(a_req_valid), .a_req_ready(a_req_ready),
    .a_req_addr(a_req_addr), .a_req_op(a_req_op),
    .a_req_data(a_req_data),
    .a_resp_valid(a_resp_valid), .a_resp_ready(a_resp_ready),
    .a_resp_resp(a_resp_resp), .a_resp_data(a_resp_data),
    .b_req_valid(b_req_valid), .b_req_ready(b_req_ready),
    .b_req_addr(b_req_addr), .b_req_op(b_req_op),
    .b_req_data(b_req_data),
    .b_resp_valid(b_resp_valid), .b_resp_ready(b_resp_ready),
    .b_resp_resp(b_resp_resp), .b_resp_data(b_resp_data),
    .dmi_req_valid(dmi_req_valid), .dmi_req_ready(dmi_req_ready),
    .dmi_req_addr(dmi_req_addr), .dmi_req_op(dmi_req_op),
    .dmi_req_data(dmi_req_data),
    .dmi_resp_valid(dmi_resp_valid),
    .dmi_resp_ready(dmi_resp_ready),
    .dmi_resp_resp(dmi_resp_resp), .dmi_resp_data(dmi_resp_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (dmi_req_valid && dmi_req_ready) hs_cnt++;
    if (b_resp_valid) b_rv_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    a_req_valid = 1; b_req_valid = 1; dmi_resp_valid = 1;
    #2;
    compared++;
    if ({a_req_ready, b_req_ready, dmi_req_valid, dmi_resp_ready,
         a_resp_valid, b_resp_valid} !== 6'b0) begin
      mismatched++;
      $display("FAIL reset_ctl: got %b want 000000",
        {a_req_ready, b_req_ready, dmi_req_valid, dmi_resp_ready,
         a_resp_valid, b_resp_valid});
    end
    tick();
    compared++;
    if ({dmi_req_addr, dmi_req_op, dmi_req_data, a_resp_data} !== '0) begin
      mismatched++;
      $display("FAIL reset_fields: got %h %h %h %h want 0",
        dmi_req_addr, dmi_req_op, dmi_req_data, a_resp_data);
    end
    a_req_valid = 0; b_req_valid = 0; dmi_resp_valid = 0;
    reset = 1'b1;
    tick();
  endtask

  task automatic test_single_read();
    a_req_valid = 1; a_req_op = 2'd1; a_req_addr = 5'h11;
    a_req_data = '0;
    #1;
    compared++;
    if ({a_req_ready, b_req_ready, dmi_req_valid} !== 3'b100) begin
      mismatched++;
      $display("FAIL single_grant: got %b want 100",
        {a_req_ready, b_req_ready, dmi_req_valid});
    end
    tick();
    a_req_valid = 0;
    compared++;
    if ({dmi_req_valid, dmi_req_addr, dmi_req_op} !== {1'b1, 5'h11, 2'd1})
    begin
      mismatched++;
      $display("FAIL single_issue: got %b %h %h want 1 11 1",
        dmi_req_valid, dmi_req_addr, dmi_req_op);
    end
    tick();
    compared++;
    if ({dmi_req_valid, dmi_resp_ready} !== 2'b01) begin
      mismatched++;
      $display("FAIL single_wait: got %b want 01",
        {dmi_req_valid, dmi_resp_ready});
    end
    tick(); tick();
    dmi_resp_valid = 1; dmi_resp_resp = 2'd0;
    dmi_resp_data = 34'h3_0000_0001;
    tick();
    dmi_resp_valid = 0;
    compared++;
    if ({a_resp_valid, b_resp_valid, a_resp_resp} !== 4'b1000 ||
        a_resp_data !== 34'h3_0000_0001) begin
      mismatched++;
      $display("FAIL single_resp: got %b%b %h %h want 1 0 0 300000001",
        a_resp_valid, b_resp_valid, a_resp_resp, a_resp_data);
    end
    tick();
    compared++;
    if (a_resp_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL single_done: got %b want 0", a_resp_valid);
    end
  endtask

  task automatic test_arbitration();
    int b0;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    b0 = b_rv_cnt;
    a_req_valid = 1; a_req_op = 2'd1; a_req_addr = 5'h03;
    b_req_valid = 1; b_req_op = 2'd2; b_req_addr = 5'h07;
    b_req_data = 34'h155;
    #1;
    compared++;
    if ({a_req_ready, b_req_ready} !== 2'b10) begin
      mismatched++;
      $display("FAIL arb_tie: got %b want 10", {a_req_ready, b_req_ready});
    end
    tick();
    a_req_valid = 0;
    compared++;
    if ({dmi_req_addr, dmi_req_op, b_req_ready} !== {5'h03, 2'd1, 1'b0})
    begin
      mismatched++;
      $display("FAIL arb_a_issue: got %h %h %b want 03 1 0",
        dmi_req_addr, dmi_req_op, b_req_ready);
    end
    tick();
    tick();
    dmi_resp_valid = 1; dmi_resp_data = 34'hAAA;
    tick();
    dmi_resp_valid = 0;
    compared++;
    if ({a_resp_valid, b_resp_valid, b_req_ready} !== 3'b100 ||
        a_resp_data !== 34'hAAA) begin
      mismatched++;
      $display("FAIL arb_a_resp: got %b %h want 100 aaa",
        {a_resp_valid, b_resp_valid, b_req_ready}, a_resp_data);
    end
    tick();
    compared++;
    if ({b_req_ready, a_resp_valid, b_rv_cnt - b0} !== {2'b10, 32'd0}) begin
      mismatched++;
      $display("FAIL arb_b_grant: got %b%b bvalid_cycles=%0d want 10 0",
        b_req_ready, a_resp_valid, b_rv_cnt - b0);
    end
    tick();
    b_req_valid = 0;
    compared++;
    if ({dmi_req_addr, dmi_req_op} !== {5'h07, 2'd2} ||
        dmi_req_data !== 34'h155) begin
      mismatched++;
      $display("FAIL arb_b_issue: got %h %h %h want 07 2 155",
        dmi_req_addr, dmi_req_op, dmi_req_data);
    end
    tick();
    dmi_resp_valid = 1; dmi_resp_data = 34'h123;
    tick();
    dmi_resp_valid = 0;
    compared++;
    if ({b_resp_valid, a_resp_valid} !== 2'b10 ||
        b_resp_data !== 34'h123) begin
      mismatched++;
      $display("FAIL arb_b_resp: got %b %h want 10 123",
        {b_resp_valid, a_resp_valid}, b_resp_data);
    end
    tick();
  endtask

  task automatic test_req_stall();
    int h0;
    h0 = hs_cnt;
    dmi_req_ready = 0;
    a_req_valid = 1; a_req_op = 2'd2; a_req_addr = 5'h1f;
    a_req_data = 34'h2_DEAD_BEEF;
    tick();
    a_req_valid = 0;
    for (int i = 0; i < 5; i++) begin
      compared++;
      if ({dmi_req_valid, dmi_req_addr, dmi_req_op} !==
          {1'b1, 5'h1f, 2'd2} || dmi_req_data !== 34'h2_DEAD_BEEF) begin
        mismatched++;
        $display("FAIL stall_hold[%0d]: got %b %h %h %h want 1 1f 2 2deadbeef",
          i, dmi_req_valid, dmi_req_addr, dmi_req_op, dmi_req_data);
      end
      tick();
    end
    dmi_req_ready = 1;
    tick();
    tick();
    compared++;
    if ({dmi_req_valid, dmi_resp_ready} !== 2'b01 || hs_cnt - h0 != 1) begin
      mismatched++;
      $display("FAIL stall_hs: got %b handshakes=%0d want 01 1",
        {dmi_req_valid, dmi_resp_ready}, hs_cnt - h0);
    end
    dmi_resp_valid = 1; dmi_resp_data = 34'h0;
    tick();
    dmi_resp_valid = 0;
    tick();
  endtask

  task automatic test_resp_hold();
    b_resp_ready = 0;
    b_req_valid = 1; b_req_op = 2'd1; b_req_addr = 5'h02;
    tick();
    b_req_valid = 0;
    tick();
    dmi_resp_valid = 1; dmi_resp_resp = 2'd3;
    dmi_resp_data = 34'h0_5A5A_5A5A;
    tick();
    dmi_resp_valid = 0; dmi_resp_resp = 2'd0;
    a_req_valid = 1; a_req_op = 2'd1; a_req_addr = 5'h04;
    for (int i = 0; i < 4; i++) begin
      compared++;
      if ({b_resp_valid, b_resp_resp, a_req_ready, a_resp_valid} !==
          5'b11100 || b_resp_data !== 34'h0_5A5A_5A5A) begin
        mismatched++;
        $display("FAIL hold[%0d]: got %b %h want 11100 5a5a5a5a", i,
          {b_resp_valid, b_resp_resp, a_req_ready, a_resp_valid},
          b_resp_data);
      end
      tick();
    end
    b_resp_ready = 1;
    tick();
    compared++;
    if ({b_resp_valid, a_req_ready} !== 2'b01) begin
      mismatched++;
      $display("FAIL hold_release: got %b want 01",
        {b_resp_valid, a_req_ready});
    end
    tick();
    a_req_valid = 0;
    tick();
    dmi_resp_valid = 1; dmi_resp_data = 34'h77;
    tick();
    dmi_resp_valid = 0;
    compared++;
    if (a_resp_valid !== 1'b1 || a_resp_data !== 34'h77) begin
      mismatched++;
      $display("FAIL hold_next: got %b %h want 1 77",
        a_resp_valid, a_resp_data);
    end
    tick();
  endtask

  task automatic test_reset_in_wait();
    a_req_valid = 1; a_req_op = 2'd1; a_req_addr = 5'h09;
    tick();
    a_req_valid = 0;
    tick();
    compared++;
    if (dmi_resp_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL rst_pre: got %b want 1", dmi_resp_ready);
    end
    #2 reset = 1'b0;
    #1;
    compared++;
    if ({a_req_ready, b_req_ready, dmi_req_valid, dmi_resp_ready,
         a_resp_valid, b_resp_valid} !== 6'b0 ||
        {dmi_req_addr, dmi_req_op} !== 7'b0) begin
      mismatched++;
      $display("FAIL rst_async: got %b %h %h want 0",
        {a_req_ready, b_req_ready, dmi_req_valid, dmi_resp_ready,
         a_resp_valid, b_resp_valid}, dmi_req_addr, dmi_req_op);
    end
    tick();
    reset = 1'b1;
    dmi_resp_valid = 1; dmi_resp_data = 34'h3FF;
    #1;
    compared++;
    if ({dmi_resp_ready, a_resp_valid} !== 2'b00) begin
      mismatched++;
      $display("FAIL rst_stray: got %b want 00",
        {dmi_resp_ready, a_resp_valid});
    end
    tick();
    dmi_resp_valid = 0;
    tick();
    compared++;
    if ({a_resp_valid, b_resp_valid, dmi_req_valid} !== 3'b000) begin
      mismatched++;
      $display("FAIL rst_quiet: got %b want 000",
        {a_resp_valid, b_resp_valid, dmi_req_valid});
    end
    b_req_valid = 1; b_req_op = 2'd2; b_req_addr = 5'h0c;
    b_req_data = 34'h1_2345_6789;
    tick();
    b_req_valid = 0;
    compared++;
    if ({dmi_req_valid, dmi_req_addr} !== {1'b1, 5'h0c} ||
        dmi_req_data !== 34'h1_2345_6789) begin
      mismatched++;
      $display("FAIL rst_after_issue: got %b %h %h want 1 0c 123456789",
        dmi_req_valid, dmi_req_addr, dmi_req_data);
    end
    tick();
    dmi_resp_valid = 1; dmi_resp_data = 34'h55;
    tick();
    dmi_resp_valid = 0;
    compared++;
    if (b_resp_valid !== 1'b1 || b_resp_data !== 34'h55) begin
      mismatched++;
      $display("FAIL rst_after_resp: got %b %h want 1 55",
        b_resp_valid, b_resp_data);
    end
    tick();
  endtask

`ifdef DMI_ARB_TIMEOUT_EN
  task automatic test_timeout();
    a_req_valid = 1; a_req_op = 2'd1; a_req_addr = 5'h01;
    tick();
    a_req_valid = 0;
    tick();
    for (int i = 1; i < 8; i++) begin
      tick();
      compared++;
      if (a_resp_valid !== 1'b0) begin
        mismatched++;
        $display("FAIL to_early[%0d]: got %b want 0", i, a_resp_valid);
      end
    end
    tick();
    compared++;
    if ({a_resp_valid, a_resp_resp} !== 3'b110 || a_resp_data !== '0) begin
      mismatched++;
      $display("FAIL to_resp: got %b %h %h want 1 2 0",
        a_resp_valid, a_resp_resp, a_resp_data);
    end
    tick();
    dmi_resp_valid = 1; dmi_resp_data = 34'hBAD;
    #1;
    compared++;
    if (dmi_resp_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL to_drain: got %b want 1", dmi_resp_ready);
    end
    tick();
    dmi_resp_valid = 0;
    tick();
    compared++;
    if ({dmi_resp_ready, a_resp_valid, b_resp_valid} !== 3'b000) begin
      mismatched++;
      $display("FAIL to_discard: got %b want 000",
        {dmi_resp_ready, a_resp_valid, b_resp_valid});
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_read();
    test_arbitration();
    test_req_stall();
    test_resp_hold();
    test_reset_in_wait();
`ifdef DMI_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
      compared, mismatched);
    $finish;
  end

endmodule

// File: doc/dmi_arbiter.md
DMI_ARBITER -- requirements
Module: dmi_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 5: DMI address width.
REQ-002 SHALL have parameter DATA_W, default 34: DMI data width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1024: response timeout in cycles, used only under DMI_ARB_TIMEOUT_EN.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 For each requester x in {a,b}, SHALL have port x_req_valid  input  1  request present.
REQ-007 SHALL have port x_req_ready  output  1  request accepted this cycle.
REQ-008 SHALL have port x_req_addr  input  ADDR_W  request address.
REQ-009 SHALL have port x_req_op  input  2  op: 0 nop, 1 read, 2 write.
REQ-010 SHALL have port x_req_data  input  DATA_W  write data.
REQ-011 SHALL have port x_resp_valid  output  1  response for x present.
REQ-012 SHALL have port x_resp_ready  input  1  x consumes the response.
REQ-013 SHALL have port x_resp_resp  output  2  response code.
REQ-014 SHALL have port x_resp_data  output  DATA_W  read data.
REQ-015 SHALL have port dmi_req_valid  output  1  request to debug module.
REQ-016 SHALL have port dmi_req_ready  input  1  debug module accepts.
REQ-017 SHALL have port dmi_req_addr  output  ADDR_W  address.
REQ-018 SHALL have port dmi_req_op  output  2  op.
REQ-019 SHALL have port dmi_req_data  output  DATA_W  data.
REQ-020 SHALL have port dmi_resp_valid  input  1  response present.
REQ-021 SHALL have port dmi_resp_ready  output  1  arbiter consumes the response.
REQ-022 SHALL have port dmi_resp_resp  input  2  response code.
REQ-023 SHALL have port dmi_resp_data  input  DATA_W  response data.

Function
REQ-024 SHALL implement FSM IDLE -> ISSUE -> WAIT -> RETURN -> IDLE, with exactly one DMI transaction outstanding.
REQ-025 IDLE: x_req_ready SHALL equal the grant to x (combinational); all other ready/valid outputs SHALL be 0.
REQ-026 Grant SHALL go to the sole valid requester; if both are valid, it SHALL go to the requester named by the priority pointer ptr (0=a, 1=b).
REQ-027 On acceptance, addr/op/data and owner SHALL be registered and the FSM SHALL enter ISSUE; dmi_req_valid SHALL rise the next cycle (1-cycle latency).
REQ-028 ISSUE: dmi_req_valid=1 with stable registered fields until dmi_req_ready, then the FSM SHALL enter WAIT.
REQ-029 WAIT: dmi_resp_ready=1; on dmi_resp_valid, resp/data SHALL be registered and the FSM SHALL enter RETURN.
REQ-030 RETURN: owner_resp_valid=1 and the non-owner's resp_valid=0 until owner_resp_ready; then the FSM SHALL return to IDLE and set ptr to the non-owner.
REQ-031 The owner SHALL be able to issue its next request no earlier than the cycle after its response handshake.
REQ-032 A dmi_resp_valid outside WAIT SHALL be ignored (dmi_resp_ready=0).
REQ-033 The other requester's req_valid asserted mid-transaction SHALL see req_ready=0 until IDLE.

Reset
REQ-034 Reset low SHALL force IDLE, ptr=0, and registered fields to 0 immediately; all outputs SHALL be 0 except grant-derived x_req_ready after release.
REQ-035 Reset mid-transaction SHALL abandon the transaction with no response returned.

Configuration
REQ-036 With DMI_ARB_TIMEOUT_EN defined, a WAIT counter SHALL enter RETURN with resp=2'b10, data=0 after TIMEOUT_CYCLES cycles without dmi_resp_valid, and SHALL discard the late response by holding dmi_resp_ready=1 in IDLE until it arrives; without the macro, WAIT SHALL be unbounded and no counter SHALL exist.

Structure
REQ-037 Package dmi_arb_pkg SHALL hold the state enum, op encodings (NOP/READ/WRITE), resp codes (OK=0, FAIL=2, BUSY=3), and a request struct.
REQ-038 The round-robin pick SHALL be a sub-module dmi_rr_pick2 (inputs: two valids, ptr; outputs: grant, any).

Verification
REQ-039 Only a valid, op=1, addr=0x11; dmi_req_ready=1; response data=0x3_0000_0001 after 3 cycles -> dmi_req_valid one cycle after acceptance; a_resp_data=0x3_0000_0001, resp=0.
REQ-040 a and b valid together after reset -> a served first, then b; b_resp_valid never asserted during a's transaction.
REQ-041 dmi_req_ready low for 5 cycles -> dmi_req_addr/op/data stable throughout; single handshake.
REQ-042 b_resp_ready held low 4 cycles in RETURN -> b_resp_valid held with stable data; no new grant until release.
REQ-043 Reset asserted in WAIT -> all outputs 0 asynchronously; the next request after release is served normally.
REQ-044 With DMI_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, no response -> owner gets resp=2 at cycle 8 of WAIT; a later stray response is consumed and not forwarded.
